// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Load/store request/response bus between CPU MEM stage and dmem.
//            Mailbox outputs exist only when DMEM_TOHOST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_TOHOST_EN
  logic        halt;
  logic [30:0] exit_code;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, halt, exit_code
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, halt, exit_code
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with programmable wait
//            states. Optional tohost mailbox enabled by macro DMEM_TOHOST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  dmem_responder_if.slave  bus
);

  localparam int          c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] c_END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  c_LAT_M1   = 4'(LATENCY - 1);
  localparam bit          c_ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_commit;
  logic               w_live;
  logic               w_we;
  logic [31:0]        w_addr;
  logic [31:0]        w_wdata;
  logic [3:0]         w_wstrb;
  logic               w_in_range;
  logic [c_IDX_W-1:0] w_idx;
  logic [7:0]         w_lane_mask;
  logic [3:0]         w_eff_strb;
  logic [31:0]        w_eff_data;
  logic               w_misal;
  logic               w_err;
  logic               w_mem_wr;
  logic [31:0]        w_rd_data;

  assign w_accept = bus.req_valid && r_req_ready;
  assign w_commit = (r_state == S_IDLE && w_accept && c_ZERO_LAT) ||
                    (r_state == S_WAIT && r_cnt == 4'd0);

  // A zero-latency access commits on its acceptance edge, before the latch.
  assign w_live  = (r_state == S_IDLE);
  assign w_we    = w_live ? bus.req_we    : r_we;
  assign w_addr  = w_live ? bus.req_addr  : r_addr;
  assign w_wdata = w_live ? bus.req_wdata : r_wdata;
  assign w_wstrb = w_live ? bus.req_wstrb : r_wstrb;

  assign w_in_range  = (w_addr >= BASE_ADDR) && ({1'b0, w_addr} < c_END_ADDR);
  assign w_idx       = c_IDX_W'((w_addr - BASE_ADDR) >> 2);
  assign w_lane_mask = 8'({4'b0000, w_wstrb} << w_addr[1:0]);
  assign w_eff_strb  = w_lane_mask[3:0];
  assign w_eff_data  = w_wdata << {w_addr[1:0], 3'b000};
  assign w_misal     = w_we ? (|w_lane_mask[7:4]) : (w_addr[1:0] != 2'b00);

`ifdef DMEM_TOHOST_EN
  logic        r_halt;
  logic [30:0] r_exit_code;
  logic        w_tohost;

  assign w_tohost  = (w_addr == TOHOST_ADDR);
  assign w_err     = w_tohost ? (w_we && (w_wstrb != 4'hF))
                              : (!w_in_range || w_misal);
  assign w_mem_wr  = w_commit && w_we && !w_err && !w_tohost && rst;
  assign w_rd_data = w_tohost ? {r_exit_code, r_halt} : r_mem[w_idx];
  assign bus.halt      = r_halt;
  assign bus.exit_code = r_exit_code;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_halt      <= 1'b0;
      r_exit_code <= 31'd0;
    end else if (w_commit && w_tohost && w_we && !w_err &&
                 w_wdata[0] && !r_halt) begin
      r_halt      <= 1'b1;
      r_exit_code <= w_wdata[31:1];
    end
  end
`else
  assign w_err     = !w_in_range || w_misal;
  assign w_mem_wr  = w_commit && w_we && !w_err && rst;
  assign w_rd_data = r_mem[w_idx];
`endif

  // Storage is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_eff_strb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_eff_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_wstrb     <= bus.req_wstrb;
            r_req_ready <= 1'b0;
            if (c_ZERO_LAT) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase

      if (w_commit) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_we || w_err) ? 32'd0 : w_rd_data;
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
